// File: rtl/easyaxi_pkg.sv
// EasyAXI shared definitions: burst/response encodings and
// read-responder FSM states.
package easyaxi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

endpackage

// File: rtl/easyaxi_rd_addr_gen.sv
// Combinational AXI burst address stepper and request legality check.
// Next address is derived from the current beat address only.
module easyaxi_rd_addr_gen
    import easyaxi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BPW_LOG2   = 3
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_len,
    input  logic [2:0]            i_size,
    input  logic [1:0]            i_burst,
    output logic [ADDR_WIDTH-1:0] o_next_addr,
    output logic                  o_illegal
);

    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_wrap_bytes;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic                  w_size_bad;
    logic                  w_len_bad;
    logic                  w_unaligned;

    assign w_step       = ADDR_WIDTH'(1) << i_size;
    assign w_incr       = i_addr + w_step;
    assign w_wrap_bytes = (ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size;
    assign w_wrap_mask  = w_wrap_bytes - ADDR_WIDTH'(1);

    assign w_size_bad  = i_size > 3'(BPW_LOG2);
    assign w_len_bad   = !(i_len inside {8'd1, 8'd3, 8'd7, 8'd15});
    assign w_unaligned = (i_addr & (w_step - ADDR_WIDTH'(1))) != '0;

    // Step the address; WRAP keeps the upper bits of the window base.
    always_comb begin
        o_next_addr = w_incr;
        unique case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_WRAP:  o_next_addr = (i_addr & ~w_wrap_mask)
                                     | (w_incr & w_wrap_mask);
            default:     o_next_addr = w_incr;
        endcase
    end

    // Whole-burst error conditions.
    always_comb begin
        o_illegal = w_size_bad || (i_burst == BURST_RSVD);
        if (i_burst == BURST_WRAP && (w_len_bad || w_unaligned))
            o_illegal = 1'b1;
    end

endmodule

// File: rtl/easyaxi_slv_rd.sv
// EasyAXI read-channel responder: one AR at a time, burst returned on R
// from a reset-initialised register array (mem[i] = i).
module easyaxi_slv_rd
    import easyaxi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast
);

    localparam int BPW      = DATA_WIDTH / 8;
    localparam int BPW_LOG2 = $clog2(BPW);
    localparam int IDX_W    = $clog2(MEM_DEPTH);

    state_t                r_state;
    logic                  r_arready;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;
    logic                  r_illegal;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_idle;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic [ADDR_WIDTH-1:0] w_cur_addr;
    logic [7:0]            w_cur_len;
    logic [2:0]            w_cur_size;
    logic [1:0]            w_cur_burst;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_illegal;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_oob;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_word;
    logic [1:0]            w_resp;
    logic [7:0]            w_cnt_nxt;
    logic                  w_next_last;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_ar_hs = arvalid && r_arready;
    assign w_r_hs  = r_rvalid && rready;

    // In IDLE the beat being produced is beat 0 from the AR inputs;
    // in READ r_addr already holds the address of the next beat.
    assign w_cur_addr  = w_idle ? araddr  : r_addr;
    assign w_cur_len   = w_idle ? arlen   : r_len;
    assign w_cur_size  = w_idle ? arsize  : r_size;
    assign w_cur_burst = w_idle ? arburst : r_burst;

    easyaxi_rd_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BPW_LOG2   (BPW_LOG2)
    ) u_addr_gen (
        .i_addr      (w_cur_addr),
        .i_len       (w_cur_len),
        .i_size      (w_cur_size),
        .i_burst     (w_cur_burst),
        .o_next_addr (w_next_addr),
        .o_illegal   (w_illegal)
    );

    assign w_idx  = w_cur_addr >> BPW_LOG2;
    assign w_oob  = w_idx >= ADDR_WIDTH'(MEM_DEPTH);
    assign w_err  = (w_idle ? w_illegal : r_illegal) || w_oob;
    assign w_word = w_err ? '0 : r_mem[w_idx[IDX_W-1:0]];
    assign w_resp = w_err ? RESP_SLVERR : RESP_OKAY;

    assign w_cnt_nxt   = r_cnt + 8'd1;
    assign w_next_last = w_idle ? (arlen == 8'd0) : (w_cnt_nxt == r_len);

    // Memory contents are (re)loaded on every reset; no write path.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                r_mem[i] <= DATA_WIDTH'(i);
        end
    end

    // Request/response FSM with registered AR and R outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rid     <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rid     <= arid;
                        r_len     <= arlen;
                        r_size    <= arsize;
                        r_burst   <= arburst;
                        r_illegal <= w_illegal;
                        r_cnt     <= '0;
                        r_addr    <= w_next_addr;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_word;
                        r_rresp   <= w_resp;
                        r_rlast   <= w_next_last;
                        r_state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_cnt   <= w_cnt_nxt;
                            r_addr  <= w_next_addr;
                            r_rdata <= w_word;
                            r_rresp <= w_resp;
                            r_rlast <= w_next_last;
                        end
                    end
                end
            endcase
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rid     = r_rid;

endmodule

// File: tb/tb_easyaxi_slv_rd.sv
// Directed self-checking bench for easyaxi_slv_rd.
module tb_easyaxi_slv_rd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    easyaxi_slv_rd #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (64),
        .ID_WIDTH   (4),
        .MEM_DEPTH  (256)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .arvalid (arvalid),
        .arready (arready),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .rvalid  (rvalid),
        .rready  (rready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast)
    );

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            arvalid = 1'b1;
            arid    = id;
            araddr  = addr;
            arlen   = len;
            arsize  = size;
            arburst = burst;
            @(posedge clk);
            #1;
            arvalid = 1'b0;
        end
    endtask

    task automatic get_beat(output logic [63:0] d, output logic [1:0] rs,
                            output logic l, output logic [3:0] id,
                            output bit ok);
        ok = 1'b0;
        d  = 'x;
        rs = 'x;
        l  = 1'bx;
        id = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid) begin
                d  = rdata;
                rs = rresp;
                l  = rlast;
                id = rid;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({arready, rvalid, rlast, rresp, rid} !== 9'd0 ||
            rdata !== 64'd0) begin
            n_err++;
            $display("FAIL reset_outputs: arready=%b rvalid=%b rlast=%b rresp=%0d rid=%0d rdata=%0d, want all 0",
                     arready, rvalid, rlast, rresp, rid, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (arready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_arready: got %b want 1", arready);
        end
    endtask

    task automatic test_incr();
        logic [63:0] d;
        logic [1:0]  rs;
        logic        l;
        logic [3:0]  id;
        bit          ok;
        logic [63:0] exp_d [4];
        exp_d = '{64'd2, 64'd3, 64'd4, 64'd5};
        rready = 1'b1;
        send_ar(4'd5, 32'h10, 8'd3, 3'd3, 2'b01, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL incr_ar: arready timeout, want accept");
        end
        for (int b = 0; b < 4; b++) begin
            get_beat(d, rs, l, id, ok);
            n_vec++;
            if (!ok || d !== exp_d[b] || rs !== 2'b00 ||
                l !== (b == 3) || id !== 4'd5) begin
                n_err++;
                $display("FAIL incr_beat%0d: got ok=%0d data=%0d resp=%0d last=%b id=%0d, want data=%0d resp=0 last=%0d id=5",
                         b, ok, d, rs, l, id, exp_d[b], (b == 3));
            end
        end
        @(negedge clk);
        n_vec++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_err++;
            $display("FAIL incr_bubble: got rvalid=%b arready=%b, want 0 1",
                     rvalid, arready);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] d;
        logic [1:0]  rs;
        logic        l;
        logic [3:0]  id;
        bit          ok;
        logic [63:0] exp_d [4];
        exp_d = '{64'd3, 64'd0, 64'd1, 64'd2};
        send_ar(4'd2, 32'h18, 8'd3, 3'd3, 2'b10, ok);
        for (int b = 0; b < 4; b++) begin
            get_beat(d, rs, l, id, ok);
            n_vec++;
            if (!ok || d !== exp_d[b] || rs !== 2'b00 || l !== (b == 3)) begin
                n_err++;
                $display("FAIL wrap_beat%0d: got ok=%0d data=%0d resp=%0d last=%b, want data=%0d resp=0 last=%0d",
                         b, ok, d, rs, l, exp_d[b], (b == 3));
            end
        end
    endtask

    task automatic test_fixed();
        logic [63:0] d;
        logic [1:0]  rs;
        logic        l;
        logic [3:0]  id;
        bit          ok;
        send_ar(4'd9, 32'h08, 8'd2, 3'd3, 2'b00, ok);
        for (int b = 0; b < 3; b++) begin
            get_beat(d, rs, l, id, ok);
            n_vec++;
            if (!ok || d !== 64'd1 || rs !== 2'b00 || l !== (b == 2) ||
                id !== 4'd9) begin
                n_err++;
                $display("FAIL fixed_beat%0d: got ok=%0d data=%0d resp=%0d last=%b id=%0d, want data=1 resp=0 last=%0d id=9",
                         b, ok, d, rs, l, id, (b == 2));
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] d;
        logic [1:0]  rs;
        logic        l;
        logic [3:0]  id;
        bit          ok;
        logic [63:0] seen [$];
        send_ar(4'd1, 32'h0, 8'd3, 3'd3, 2'b01, ok);
        get_beat(d, rs, l, id, ok);
        if (ok) seen.push_back(d);
        @(negedge clk);
        rready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (rvalid !== 1'b1 || rdata !== 64'd1 || rlast !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold%0d: got rvalid=%b data=%0d last=%b, want 1 1 0",
                         c, rvalid, rdata, rlast);
            end
        end
        if (rvalid) seen.push_back(rdata);
        rready = 1'b1;
        for (int b = 2; b < 4; b++) begin
            get_beat(d, rs, l, id, ok);
            if (ok) seen.push_back(d);
        end
        n_vec++;
        if (seen.size() != 4 || seen[0] !== 64'd0 || seen[1] !== 64'd1 ||
            seen[2] !== 64'd2 || seen[3] !== 64'd3 || l !== 1'b1) begin
            n_err++;
            $display("FAIL stall_seq: got %0d beats last=%b, want 4 beats 0,1,2,3 last=1",
                     seen.size(), l);
        end
    endtask

    task automatic test_errors();
        logic [63:0] d;
        logic [1:0]  rs;
        logic        l;
        logic [3:0]  id;
        bit          ok;
        send_ar(4'd3, 32'h7F8, 8'd1, 3'd3, 2'b01, ok);
        get_beat(d, rs, l, id, ok);
        n_vec++;
        if (!ok || d !== 64'd255 || rs !== 2'b00 || l !== 1'b0) begin
            n_err++;
            $display("FAIL edge_beat0: got ok=%0d data=%0d resp=%0d last=%b, want 255 0 0",
                     ok, d, rs, l);
        end
        get_beat(d, rs, l, id, ok);
        n_vec++;
        if (!ok || d !== 64'd0 || rs !== 2'b10 || l !== 1'b1) begin
            n_err++;
            $display("FAIL oob_beat1: got ok=%0d data=%0d resp=%0d last=%b, want 0 2 1",
                     ok, d, rs, l);
        end
        send_ar(4'd4, 32'h20, 8'd2, 3'd3, 2'b10, ok);
        for (int b = 0; b < 3; b++) begin
            get_beat(d, rs, l, id, ok);
            n_vec++;
            if (!ok || d !== 64'd0 || rs !== 2'b10 || l !== (b == 2)) begin
                n_err++;
                $display("FAIL wraplen_beat%0d: got ok=%0d data=%0d resp=%0d last=%b, want 0 2 %0d",
                         b, ok, d, rs, l, (b == 2));
            end
        end
        send_ar(4'd6, 32'h40, 8'd0, 3'd4, 2'b01, ok);
        get_beat(d, rs, l, id, ok);
        n_vec++;
        if (!ok || d !== 64'd0 || rs !== 2'b10 || l !== 1'b1) begin
            n_err++;
            $display("FAIL bigsize: got ok=%0d data=%0d resp=%0d last=%b, want 0 2 1",
                     ok, d, rs, l);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] d;
        logic [1:0]  rs;
        logic        l;
        logic [3:0]  id;
        bit          ok;
        send_ar(4'd7, 32'h0, 8'd7, 3'd3, 2'b01, ok);
        get_beat(d, rs, l, id, ok);
        get_beat(d, rs, l, id, ok);
        @(negedge clk);
        n_vec++;
        if (rvalid !== 1'b1 || rdata !== 64'd2) begin
            n_err++;
            $display("FAIL midrst_beat2: got rvalid=%b data=%0d, want 1 2",
                     rvalid, rdata);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (rvalid !== 1'b0 || arready !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_abort: got rvalid=%b arready=%b, want 0 0",
                     rvalid, arready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_ready: got arready=%b rvalid=%b, want 1 0",
                     arready, rvalid);
        end
        send_ar(4'd8, 32'h0, 8'd0, 3'd3, 2'b01, ok);
        get_beat(d, rs, l, id, ok);
        n_vec++;
        if (!ok || d !== 64'd0 || rs !== 2'b00 || l !== 1'b1 ||
            id !== 4'd8) begin
            n_err++;
            $display("FAIL midrst_single: got ok=%0d data=%0d resp=%0d last=%b id=%0d, want 0 0 1 8",
                     ok, d, rs, l, id);
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_stall();
        test_errors();
        test_reset_mid_burst();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
